// File: rtl/rf_write_buffer.sv
// Write-back FIFO feeding the register file's single write port, with two
// combinational bypass lookups returning the youngest pending value per address.
module rf_wb_lookup #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 64,
   parameter int AW    = 5
) (
   input  logic [$clog2(DEPTH)-1:0]       head,
   input  logic [$clog2(DEPTH):0]         cnt,
   input  logic [DEPTH-1:0][AW-1:0]       rd_mem,
   input  logic [DEPTH-1:0][XLEN-1:0]     data_mem,
   input  logic [AW-1:0]                  addr,
   output logic                           hit,
   output logic [XLEN-1:0]                data
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // Walk oldest to youngest so the last match (nearest tail) wins.
   always_comb begin
      logic [PW-1:0] idx;
      idx  = '0;
      hit  = 1'b0;
      data = '0;
      for (int a = 0; a < DEPTH; a++) begin
         idx = head + PW'(a);
         if ((CW'(a) < cnt) && (rd_mem[idx] == addr) && (addr != '0)) begin
            hit  = 1'b1;
            data = data_mem[idx];
         end
      end
   end
endmodule

module rf_write_buffer #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 64,
   parameter int AW    = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [AW-1:0]             in_rd,
   input  logic [XLEN-1:0]           in_data,
   input  logic                      rf_grant,
   output logic                      rf_we,
   output logic [AW-1:0]             rf_waddr,
   output logic [XLEN-1:0]           rf_wdata,
   input  logic [AW-1:0]             q1_addr,
   input  logic [AW-1:0]             q2_addr,
   output logic                      q1_hit,
   output logic                      q2_hit,
   output logic [XLEN-1:0]           q1_data,
   output logic [XLEN-1:0]           q2_data,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DEPTH-1:0][AW-1:0]   rd_mem;
   logic [DEPTH-1:0][XLEN-1:0] data_mem;
   logic [PW-1:0]              head, tail;
   logic [CW-1:0]              cnt;
   logic                       push, pop;

   assign in_ready = !rst && (cnt < CW'(DEPTH));
   // Writes to x0 are accepted but dropped: they never reach the queue.
   assign push     = in_valid && in_ready && (in_rd != '0);
   assign rf_we    = (cnt != '0);
   assign pop      = rf_we && rf_grant;
   assign rf_waddr = rd_mem[head];
   assign rf_wdata = data_mem[head];
   assign count    = cnt;
   assign empty    = (cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         rd_mem[tail]   <= in_rd;
         data_mem[tail] <= in_data;
      end
   end

   logic [1:0][AW-1:0]   q_addr;
   logic [1:0]           q_hit;
   logic [1:0][XLEN-1:0] q_data;

   assign q_addr  = {q2_addr, q1_addr};
   assign q1_hit  = q_hit[0];
   assign q2_hit  = q_hit[1];
   assign q1_data = q_data[0];
   assign q2_data = q_data[1];

   for (genvar p = 0; p < 2; p++) begin : g_lookup
      rf_wb_lookup #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) u_lookup (
         .head     (head),
         .cnt      (cnt),
         .rd_mem   (rd_mem),
         .data_mem (data_mem),
         .addr     (q_addr[p]),
         .hit      (q_hit[p]),
         .data     (q_data[p])
      );
   end
endmodule

// File: tb/tb_rf_write_buffer.sv
// Bench for rf_write_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rf_write_buffer;
   localparam int DEPTH = 4;
   localparam int XLEN  = 64;
   localparam int AW    = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [AW-1:0]   in_rd;
   logic [XLEN-1:0] in_data;
   logic            rf_grant;
   logic            rf_we;
   logic [AW-1:0]   rf_waddr;
   logic [XLEN-1:0] rf_wdata;
   logic [AW-1:0]   q1_addr, q2_addr;
   logic            q1_hit, q2_hit;
   logic [XLEN-1:0] q1_data, q2_data;
   logic [$clog2(DEPTH):0] count;
   logic            empty;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   rf_write_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_rd(in_rd), .in_data(in_data), .rf_grant(rf_grant), .rf_we(rf_we),
      .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .q1_addr(q1_addr), .q2_addr(q2_addr),
      .q1_hit(q1_hit), .q2_hit(q2_hit), .q1_data(q1_data), .q2_data(q2_data),
      .count(count), .empty(empty)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pending writes in acceptance order.
   typedef struct { logic [AW-1:0] rd; logic [XLEN-1:0] data; } ent_t;
   ent_t mq[$];

   function automatic void lookup(input logic [AW-1:0] a, output logic h, output logic [XLEN-1:0] d);
      h = 1'b0;
      d = '0;
      if (a != 0)
         for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].rd == a) begin
               h = 1'b1;
               d = mq[i].data;
               break;
            end
   endfunction

   // Compare process: check outputs mid-cycle, then advance the model to the next edge.
   initial begin
      logic h;
      logic [XLEN-1:0] d;
      logic acc, pp;
      @(posedge clk);
      forever begin
         @(negedge clk);
         check("in_ready", in_ready, (!rst && mq.size() < DEPTH));
         check("count", count, mq.size());
         check("empty", empty, mq.size() == 0);
         check("rf_we", rf_we, mq.size() != 0);
         if (mq.size() != 0) begin
            check("rf_waddr", rf_waddr, mq[0].rd);
            check("rf_wdata", rf_wdata, mq[0].data);
         end
         lookup(q1_addr, h, d);
         check("q1_hit", q1_hit, h);
         check("q1_data", q1_data, d);
         lookup(q2_addr, h, d);
         check("q2_hit", q2_hit, h);
         check("q2_data", q2_data, d);
         if (rst) mq.delete();
         else begin
            acc = in_valid && (mq.size() < DEPTH);
            pp  = (mq.size() != 0) && rf_grant;
            if (pp) void'(mq.pop_front());
            if (acc && in_rd != 0) mq.push_back('{rd: in_rd, data: in_data});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [AW-1:0] rd, input logic [XLEN-1:0] dt);
      in_valid = 1'b1; in_rd = rd; in_data = dt;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0; rf_grant = 1'b0;
      q1_addr = '0; q2_addr = '0;
      tick(); tick();
      rst = 1'b0;
      #1;
      check("rst_we", rf_we, 0);
      check("rst_empty", empty, 1);
      check("rst_count", count, 0);
      check("rst_q1hit", q1_hit, 0);
      check("rst_ready", in_ready, 1);

      // Single write drains in one cycle.
      rf_grant = 1'b1;
      push(5, 64'hDEAD_BEEF);
      #1;
      check("single_we", rf_we, 1);
      check("single_addr", rf_waddr, 5);
      check("single_data", rf_wdata, 64'hDEAD_BEEF);
      tick();
      check("single_empty", empty, 1);
      check("single_we0", rf_we, 0);

      // Fill and backpressure.
      rf_grant = 1'b0;
      for (int i = 1; i <= 4; i++) push(AW'(i), 64'(i * 'h11));
      in_valid = 1'b1; in_rd = 5; in_data = 'h55;
      #1;
      check("full_ready", in_ready, 0);
      check("full_count", count, 4);
      tick();
      in_valid = 1'b0;
      check("full_count2", count, 4);
      rf_grant = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         #1;
         check("drain_addr", rf_waddr, i);
         check("drain_data", rf_wdata, i * 'h11);
         tick();
         if (i == 1) check("ready_after_pop", in_ready, 1);
      end
      check("drain_empty", empty, 1);

      // Bypass youngest wins.
      rf_grant = 1'b0;
      push(7, 'hA); push(7, 'hB); push(3, 'hC);
      q1_addr = 7; q2_addr = 3;
      #1;
      check("byp_q1hit", q1_hit, 1);
      check("byp_q1data", q1_data, 'hB);
      check("byp_q2hit", q2_hit, 1);
      check("byp_q2data", q2_data, 'hC);
      q1_addr = 8;
      #1;
      check("byp_miss_hit", q1_hit, 0);
      check("byp_miss_data", q1_data, 0);
      rf_grant = 1'b1;
      tick(); tick(); tick();
      check("byp_empty", empty, 1);

      // x0 writes are swallowed.
      rf_grant = 1'b0;
      in_valid = 1'b1; in_rd = 0; in_data = 'hFFFF;
      #1;
      check("x0_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      q1_addr = 0;
      #1;
      check("x0_count", count, 0);
      check("x0_we", rf_we, 0);
      check("x0_hit", q1_hit, 0);

      // Simultaneous push and pop.
      push(9, 'h90); push(10, 'hA0);
      rf_grant = 1'b1;
      in_valid = 1'b1; in_rd = 11; in_data = 'hB0;
      #1;
      check("pp_head", rf_waddr, 9);
      tick();
      in_valid = 1'b0;
      check("pp_count", count, 2);
      check("pp_head2", rf_waddr, 10);
      tick();
      check("pp_last", rf_waddr, 11);
      check("pp_lastdata", rf_wdata, 'hB0);
      tick();
      check("pp_empty", empty, 1);

      // Reset mid-drain.
      rf_grant = 1'b0;
      push(12, 'h1); push(13, 'h2); push(14, 'h3);
      check("mid_count", count, 3);
      rf_grant = 1'b1; rst = 1'b1; q1_addr = 13;
      in_valid = 1'b1; in_rd = 15; in_data = 'h4;
      #1;
      check("mid_ready_rst", in_ready, 0);
      tick();
      rst = 1'b0; in_valid = 1'b0;
      #1;
      check("mid_we", rf_we, 0);
      check("mid_count0", count, 0);
      check("mid_hit", q1_hit, 0);
      tick(); tick();
      check("mid_we_later", rf_we, 0);

      // Randomized traffic; the compare process checks every cycle.
      for (int c = 0; c < 3000; c++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_rd    = AW'($urandom_range(0, 7));
         in_data  = {$urandom, $urandom};
         rf_grant = ($urandom_range(0, 2) == 0) || (c > 2000 && $urandom_range(0, 1) == 0);
         q1_addr  = AW'($urandom_range(0, 7));
         q2_addr  = AW'($urandom_range(0, 7));
         rst      = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst = 1'b0; in_valid = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
